// File: rtl/board_state_store.sv
// board_state_store: holds the own and enemy 10x10 Battleship grids (2-bit cells),
// runs one game command per handshake, and drives registered row vectors to the display.
module board_state_store #(
  parameter int NUM_ROWS       = 10,
  parameter int MAX_SHIP_CELLS = 17
) (
  input  logic                    clock50,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [3:0]              cmd_row,
  input  logic [3:0]              cmd_col,
  input  logic                    cmd_hit,
  output logic                    resp_valid,
  output logic [2:0]              resp_code,
  output logic [2*NUM_ROWS-1:0]   A, B, C, D, E, F, G, H, I, J,
  output logic [2*NUM_ROWS-1:0]   OA, OB, OC, OD, OE, OF, OG, OH, OI, OJ,
  output logic                    player_turn,
  output logic [4:0]              ships_left,
  output logic                    game_over
);

  localparam int RW = 2 * NUM_ROWS;

  localparam logic [1:0] CELL_WATER = 2'b00;
  localparam logic [1:0] CELL_SHIP  = 2'b01;
  localparam logic [1:0] CELL_MISS  = 2'b10;
  localparam logic [1:0] CELL_HIT   = 2'b11;

  localparam logic [2:0] RESP_OK      = 3'b000;
  localparam logic [2:0] RESP_MISS    = 3'b001;
  localparam logic [2:0] RESP_HIT     = 3'b010;
  localparam logic [2:0] RESP_REPEAT  = 3'b011;
  localparam logic [2:0] RESP_INVALID = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
  typedef enum logic [1:0] {OP_PLACE = 2'b00, OP_FIRE_IN = 2'b01,
                            OP_RECORD = 2'b10, OP_START = 2'b11} op_t;
  typedef enum logic {PH_SETUP, PH_PLAY} phase_t;

  state_t         state_q, state_d;
  phase_t         phase_q, phase_d;
  op_t            op_q, op_d;
  logic [3:0]     row_q, row_d;
  logic [3:0]     col_q, col_d;
  logic           hit_q, hit_d;
  logic [RW-1:0]  own_q [NUM_ROWS];
  logic [RW-1:0]  own_d [NUM_ROWS];
  logic [RW-1:0]  enemy_q [NUM_ROWS];
  logic [RW-1:0]  enemy_d [NUM_ROWS];
  logic [RW-1:0]  own_rows_q [NUM_ROWS];
  logic [RW-1:0]  own_rows_d [NUM_ROWS];
  logic [RW-1:0]  enemy_rows_q [NUM_ROWS];
  logic [RW-1:0]  enemy_rows_d [NUM_ROWS];
  logic           resp_valid_q, resp_valid_d;
  logic [2:0]     resp_code_q, resp_code_d;
  logic           turn_q, turn_d;
  logic [4:0]     ships_q, ships_d;
  logic           over_q, over_d;

  logic           in_range;
  logic [3:0]     row_idx;
  logic [3:0]     col_idx;
  logic [4:0]     bit_lo;
  logic [1:0]     own_cell;
  logic [1:0]     enemy_cell;

  // Next-state logic: handshake sequencing plus the command's effect on grids and counters.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    op_d         = op_q;
    row_d        = row_q;
    col_d        = col_q;
    hit_d        = hit_q;
    own_d        = own_q;
    enemy_d      = enemy_q;
    own_rows_d   = own_q;
    enemy_rows_d = enemy_q;
    resp_valid_d = 1'b0;
    resp_code_d  = resp_code_q;
    turn_d       = turn_q;
    ships_d      = ships_q;
    over_d       = over_q;

    in_range   = (row_q < 4'(NUM_ROWS)) && (col_q < 4'(NUM_ROWS));
    row_idx    = in_range ? row_q : 4'd0;
    col_idx    = in_range ? col_q : 4'd0;
    bit_lo     = 5'(RW - 2) - {col_idx, 1'b0};
    own_cell   = own_q[row_idx][bit_lo +: 2];
    enemy_cell = enemy_q[row_idx][bit_lo +: 2];

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_t'(cmd_op);
          row_d   = cmd_row;
          col_d   = cmd_col;
          hit_d   = cmd_hit;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        resp_valid_d = 1'b1;
        resp_code_d  = RESP_INVALID;
        state_d      = S_RESP;
        if (!over_q) begin
          case (op_q)
            OP_PLACE: begin
              if (phase_q == PH_SETUP && in_range && own_cell == CELL_WATER &&
                  ships_q < 5'(MAX_SHIP_CELLS)) begin
                own_d[row_idx][bit_lo +: 2] = CELL_SHIP;
                ships_d     = ships_q + 5'd1;
                resp_code_d = RESP_OK;
              end
            end
            OP_START: begin
              if (phase_q == PH_SETUP && ships_q != 5'd0) begin
                phase_d     = PH_PLAY;
                resp_code_d = RESP_OK;
              end
            end
            OP_FIRE_IN: begin
              if (phase_q == PH_PLAY && in_range) begin
                if (own_cell == CELL_WATER) begin
                  own_d[row_idx][bit_lo +: 2] = CELL_MISS;
                  turn_d      = ~turn_q;
                  resp_code_d = RESP_MISS;
                end else if (own_cell == CELL_SHIP) begin
                  own_d[row_idx][bit_lo +: 2] = CELL_HIT;
                  turn_d      = ~turn_q;
                  resp_code_d = RESP_HIT;
                  if (ships_q != 5'd0) begin
                    ships_d = ships_q - 5'd1;
                  end
                  if (ships_q <= 5'd1) begin
                    over_d = 1'b1;
                  end
                end else begin
                  resp_code_d = RESP_REPEAT;
                end
              end
            end
            OP_RECORD: begin
              if (phase_q == PH_PLAY && in_range) begin
                if (enemy_cell == CELL_WATER) begin
                  enemy_d[row_idx][bit_lo +: 2] = hit_q ? CELL_HIT : CELL_MISS;
                  turn_d      = ~turn_q;
                  resp_code_d = hit_q ? RESP_HIT : RESP_MISS;
                end else begin
                  resp_code_d = RESP_REPEAT;
                end
              end
            end
            default: resp_code_d = RESP_INVALID;
          endcase
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset also drops any command in flight.
  always_ff @(posedge clock50) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_q      <= PH_SETUP;
      op_q         <= OP_PLACE;
      row_q        <= 4'd0;
      col_q        <= 4'd0;
      hit_q        <= 1'b0;
      own_q        <= '{default: '0};
      enemy_q      <= '{default: '0};
      own_rows_q   <= '{default: '0};
      enemy_rows_q <= '{default: '0};
      resp_valid_q <= 1'b0;
      resp_code_q  <= RESP_OK;
      turn_q       <= 1'b0;
      ships_q      <= 5'd0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      op_q         <= op_d;
      row_q        <= row_d;
      col_q        <= col_d;
      hit_q        <= hit_d;
      own_q        <= own_d;
      enemy_q      <= enemy_d;
      own_rows_q   <= own_rows_d;
      enemy_rows_q <= enemy_rows_d;
      resp_valid_q <= resp_valid_d;
      resp_code_q  <= resp_code_d;
      turn_q       <= turn_d;
      ships_q      <= ships_d;
      over_q       <= over_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_code   = resp_code_q;
  assign player_turn = turn_q;
  assign ships_left  = ships_q;
  assign game_over   = over_q;

  assign A  = own_rows_q[0];
  assign B  = own_rows_q[1];
  assign C  = own_rows_q[2];
  assign D  = own_rows_q[3];
  assign E  = own_rows_q[4];
  assign F  = own_rows_q[5];
  assign G  = own_rows_q[6];
  assign H  = own_rows_q[7];
  assign I  = own_rows_q[8];
  assign J  = own_rows_q[9];
  assign OA = enemy_rows_q[0];
  assign OB = enemy_rows_q[1];
  assign OC = enemy_rows_q[2];
  assign OD = enemy_rows_q[3];
  assign OE = enemy_rows_q[4];
  assign OF = enemy_rows_q[5];
  assign OG = enemy_rows_q[6];
  assign OH = enemy_rows_q[7];
  assign OI = enemy_rows_q[8];
  assign OJ = enemy_rows_q[9];

endmodule
